// File: rtl/uart_echo.sv
// uart_echo: UART receive -> FIFO -> UART transmit loopback.
// Frames are 1 start bit, DATA_BITS data bits LSB first, optional parity and
// 1 stop bit. Good bytes are buffered and retransmitted in the same format.
//
// Internal handshakes:
//   push: push_q is a one-cycle valid from RX. The FIFO accepts it when not full.
//         Full is taken from the pointers before any same-cycle pop. If the FIFO
//         is full the byte is dropped and ovf pulses in that same cycle.
//   pop:  pop_fire is asserted only in TX_IDLE while the FIFO is non-empty and
//         tx_pause is low. TX captures the head entry on the same edge that
//         advances the read pointer.
module uart_echo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic                          uart_tx,
  input  logic                          tx_pause,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [2:0]                    rx_state_o,
  output logic [2:0]                    tx_state_o
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BIT_W = 4;

  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_PAR   = 3'd3,
    RX_STOP  = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_STOP  = 3'd4
  } tx_state_t;

  // Parity bit that goes with a data word: odd makes the total 1-count odd.
  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------------------------------------------------------------------
  // RX input conditioning
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q, prev_q;
  logic rx_s, rx_fall;

  // Two-flop synchroniser followed by one edge-detect register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s    = sync2_q;
  assign rx_fall = prev_q & ~sync2_q;

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  rx_state_t              rx_state_q;
  logic [CNT_W-1:0]       rx_cnt_q;
  logic [BIT_W-1:0]       rx_bit_q;
  logic [DATA_BITS-1:0]   rx_shift_q;
  logic                   rx_par_bad_q;
  logic                   push_q;
  logic [DATA_BITS-1:0]   push_data_q;
  logic                   frame_err_q;
  logic                   parity_err_q;

  // Receive one frame; the outcome (push or one error flag) is registered at
  // the stop sample so it is visible in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_bad_q <= 1'b0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_cnt_q   <= CNT_HALF;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == CNT_ONE) begin
            if (!rx_s) begin
              rx_cnt_q     <= CNT_DIV;
              rx_bit_q     <= '0;
              rx_par_bad_q <= 1'b0;
              rx_state_q   <= RX_DATA;
            end else begin
              // Line went back high before mid start bit: a glitch.
              rx_state_q <= RX_IDLE;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == CNT_ONE) begin
            rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
            rx_cnt_q   <= CNT_DIV;
            if (rx_bit_q == BIT_LAST) begin
              rx_bit_q   <= '0;
              rx_state_q <= (PARITY != 0) ? RX_PAR : RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + BIT_ONE;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_ONE;
          end
        end
        RX_PAR: begin
          if (rx_cnt_q == CNT_ONE) begin
            rx_par_bad_q <= (rx_s != par_of(rx_shift_q));
            rx_cnt_q     <= CNT_DIV;
            rx_state_q   <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == CNT_ONE) begin
            rx_state_q <= RX_IDLE;
            if (!rx_s) begin
              frame_err_q <= 1'b1;
            end else if (rx_par_bad_q) begin
              parity_err_q <= 1'b1;
            end else begin
              push_q      <= 1'b1;
              push_data_q <= rx_shift_q;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_ONE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic                 fifo_full, fifo_empty;
  logic                 push_fire, pop_fire;
  logic [DATA_BITS-1:0] pop_data;
  tx_state_t            tx_state_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push_fire  = push_q & ~fifo_full;
  assign pop_fire   = (tx_state_q == TX_IDLE) & ~fifo_empty & ~tx_pause;
  assign pop_data   = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_level = wr_ptr_q - rd_ptr_q;

  // Pointers are one bit wider than the address so full and empty differ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_fire) fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_data_q;
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]     tx_cnt_q;
  logic [BIT_W-1:0]     tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 tx_q;

  // Transmit one frame per popped byte. The TX_IDLE decision cycle is the
  // last cycle of the stop bit, so TX_STOP itself holds for DIV-1 cycles and
  // back-to-back frames have exactly DIV cycles of stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (pop_fire) begin
            tx_shift_q <= pop_data;
            tx_par_q   <= par_of(pop_data);
            tx_q       <= 1'b0;
            tx_cnt_q   <= CNT_DIV;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == CNT_ONE) begin
            tx_q       <= tx_shift_q[0];
            tx_cnt_q   <= CNT_DIV;
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == CNT_ONE) begin
            tx_cnt_q <= CNT_DIV;
            if (tx_bit_q == BIT_LAST) begin
              if (PARITY != 0) begin
                tx_q       <= tx_par_q;
                tx_state_q <= TX_PAR;
              end else begin
                tx_q       <= 1'b1;
                tx_cnt_q   <= CNT_STOP;
                tx_state_q <= TX_STOP;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + BIT_ONE;
              tx_shift_q <= tx_shift_q >> 1;
              tx_q       <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_ONE;
          end
        end
        TX_PAR: begin
          if (tx_cnt_q == CNT_ONE) begin
            tx_q       <= 1'b1;
            tx_cnt_q   <= CNT_STOP;
            tx_state_q <= TX_STOP;
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_ONE;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == CNT_ONE) begin
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_ONE;
          end
        end
        default: begin
          tx_q       <= 1'b1;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign uart_tx    = tx_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign ovf        = push_q & fifo_full;
  assign rx_state_o = rx_state_q;
  assign tx_state_o = tx_state_q;

endmodule

// File: tb/tb_uart_echo.sv
// Bench for uart_echo: three instances (8N1 depth 16, 8E1 depth 16,
// 8N1 depth 4) share clock and reset; a scoreboard queue holds the bytes
// expected on uart_tx.
module tb_uart_echo;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int HALF   = DIV / 2;
  localparam int TMO    = 40 * DIV;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       rx_n, tx_n, pause_n, ferr_n, perr_n, ovf_n;
  logic [4:0] lvl_n;
  logic [2:0] rx_st_n, tx_st_n;
  logic       rx_p, tx_p, pause_p, ferr_p, perr_p, ovf_p;
  logic [4:0] lvl_p;
  logic [2:0] rx_st_p, tx_st_p;
  logic       rx_o, tx_o, pause_o, ferr_o, perr_o, ovf_o;
  logic [2:0] lvl_o;
  logic [2:0] rx_st_o, tx_st_o;

  uart_echo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)) dut_n (
    .clk(clk), .rst(rst), .uart_rx(rx_n), .uart_tx(tx_n), .tx_pause(pause_n),
    .frame_err(ferr_n), .parity_err(perr_n), .ovf(ovf_n), .fifo_level(lvl_n),
    .rx_state_o(rx_st_n), .tx_state_o(tx_st_n));

  uart_echo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16)) dut_p (
    .clk(clk), .rst(rst), .uart_rx(rx_p), .uart_tx(tx_p), .tx_pause(pause_p),
    .frame_err(ferr_p), .parity_err(perr_p), .ovf(ovf_p), .fifo_level(lvl_p),
    .rx_state_o(rx_st_p), .tx_state_o(tx_st_p));

  uart_echo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut_o (
    .clk(clk), .rst(rst), .uart_rx(rx_o), .uart_tx(tx_o), .tx_pause(pause_o),
    .frame_err(ferr_o), .parity_err(perr_o), .ovf(ovf_o), .fifo_level(lvl_o),
    .rx_state_o(rx_st_o), .tx_state_o(tx_st_o));

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  // ---------------- passive monitors ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ferr_cnt_n = 0, perr_cnt_n = 0, ovf_cnt_n = 0;
  int ferr_cnt_p = 0, perr_cnt_p = 0, ovf_cnt_p = 0;
  int ferr_cnt_o = 0, perr_cnt_o = 0, ovf_cnt_o = 0;
  int low_n = 0, low_p = 0, low_o = 0;
  int rise_cyc_n = 0;
  logic [4:0] lvl_n_prev = '0;

  always @(negedge clk) begin
    if (ferr_n === 1'b1) ferr_cnt_n <= ferr_cnt_n + 1;
    if (perr_n === 1'b1) perr_cnt_n <= perr_cnt_n + 1;
    if (ovf_n  === 1'b1) ovf_cnt_n  <= ovf_cnt_n + 1;
    if (ferr_p === 1'b1) ferr_cnt_p <= ferr_cnt_p + 1;
    if (perr_p === 1'b1) perr_cnt_p <= perr_cnt_p + 1;
    if (ovf_p  === 1'b1) ovf_cnt_p  <= ovf_cnt_p + 1;
    if (ferr_o === 1'b1) ferr_cnt_o <= ferr_cnt_o + 1;
    if (perr_o === 1'b1) perr_cnt_o <= perr_cnt_o + 1;
    if (ovf_o  === 1'b1) ovf_cnt_o  <= ovf_cnt_o + 1;
    if (tx_n === 1'b0) low_n <= low_n + 1;
    if (tx_p === 1'b0) low_p <= low_p + 1;
    if (tx_o === 1'b0) low_o <= low_o + 1;
    if (lvl_n > lvl_n_prev) rise_cyc_n <= cyc;
    lvl_n_prev <= lvl_n;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_line(input int sel);
    case (sel)
      0:       return tx_n;
      1:       return tx_p;
      default: return tx_o;
    endcase
  endfunction

  task automatic drive_rx(input int sel, input logic v);
    case (sel)
      0:       rx_n = v;
      1:       rx_p = v;
      default: rx_o = v;
    endcase
  endtask

  // Drive one serial frame; parity and stop bit values are chosen by caller.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit with_par,
                            input logic par_v, input logic stop_v);
    @(negedge clk);
    drive_rx(sel, 1'b0);
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive_rx(sel, d[i]);
      repeat (DIV) @(negedge clk);
    end
    if (with_par) begin
      drive_rx(sel, par_v);
      repeat (DIV) @(negedge clk);
    end
    drive_rx(sel, stop_v);
    repeat (DIV) @(negedge clk);
    drive_rx(sel, 1'b1);
  endtask

  // Decode one frame from a DUT uart_tx, sampling each bit at its middle.
  task automatic recv_frame(input int sel, input bit with_par, output logic [7:0] d,
                            output logic p, output int fall_cyc);
    int waited;
    waited = 0;
    d = '0;
    p = 1'b0;
    fall_cyc = 0;
    @(negedge clk);
    while (tx_line(sel) !== 1'b0 && waited < TMO) begin
      @(negedge clk);
      waited++;
    end
    check("tx_start_seen", 32'(waited < TMO), 32'd1);
    if (waited >= TMO) return;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    check("tx_start_bit", 32'(tx_line(sel)), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      d[i] = tx_line(sel);
    end
    if (with_par) begin
      repeat (DIV) @(negedge clk);
      p = tx_line(sel);
    end
    repeat (DIV) @(negedge clk);
    check("tx_stop_bit", 32'(tx_line(sel)), 32'd1);
  endtask

  // Receive a frame and compare it with the head of the scoreboard.
  task automatic expect_echo(input int sel, input bit with_par, output int fall_cyc);
    logic [7:0] d;
    logic       p;
    logic [7:0] e;
    recv_frame(sel, with_par, d, p, fall_cyc);
    check("scoreboard_has_entry", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("echo_byte", 32'(d), 32'(e));
      if (with_par) check("echo_even_parity", 32'(p), 32'(^e));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int fall, w, s_f, s_p, s_o, s_low;
    int falls[4];
    logic [7:0] rb;

    rst = 1'b1;
    rx_n = 1'b1; rx_p = 1'b1; rx_o = 1'b1;
    pause_n = 1'b0; pause_p = 1'b0; pause_o = 1'b0;
    repeat (4) @(negedge clk);

    // Reset values.
    check("rst_tx_n", 32'(tx_n), 32'd1);
    check("rst_tx_p", 32'(tx_p), 32'd1);
    check("rst_tx_o", 32'(tx_o), 32'd1);
    check("rst_lvl_n", 32'(lvl_n), 32'd0);
    check("rst_lvl_o", 32'(lvl_o), 32'd0);
    check("rst_flags_n", 32'({ferr_n, perr_n, ovf_n}), 32'd0);
    check("rst_states", 32'({rx_st_n, tx_st_n, rx_st_p, tx_st_p, rx_st_o, tx_st_o}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Echo 0x55 with push-to-start timing.
    s_f = ferr_cnt_n + perr_cnt_n + ovf_cnt_n;
    exp_q.push_back(8'h55);
    fork
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
      expect_echo(0, 1'b0, fall);
    join
    // fifo_level rises at the end of the push cycle.
    check("push_to_start_cycles", 32'(fall - (rise_cyc_n - 1)), 32'd2);
    repeat (4) @(negedge clk);
    check("echo_lvl_back_to_0", 32'(lvl_n), 32'd0);
    check("echo_no_flags", 32'(ferr_cnt_n + perr_cnt_n + ovf_cnt_n - s_f), 32'd0);

    // A few random bytes.
    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      fork
        send_frame(0, rb, 1'b0, 1'b0, 1'b1);
        expect_echo(0, 1'b0, fall);
      join
      check("rand_push_to_start", 32'(fall - (rise_cyc_n - 1)), 32'd2);
      repeat (4) @(negedge clk);
    end

    // Even parity: good parity echoes, bad parity flags and is dropped.
    exp_q.push_back(8'hA3);
    fork
      send_frame(1, 8'hA3, 1'b1, 1'b0, 1'b1);
      expect_echo(1, 1'b1, fall);
    join
    repeat (4) @(negedge clk);
    s_p = perr_cnt_p; s_f = ferr_cnt_p; s_low = low_p;
    send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1);
    repeat (3 * DIV) @(negedge clk);
    check("bad_parity_perr_pulse", 32'(perr_cnt_p - s_p), 32'd1);
    check("bad_parity_no_ferr", 32'(ferr_cnt_p - s_f), 32'd0);
    check("bad_parity_tx_idle", 32'(low_p - s_low), 32'd0);
    check("bad_parity_lvl", 32'(lvl_p), 32'd0);

    // Framing error: stop bit low.
    s_f = ferr_cnt_n; s_p = perr_cnt_n; s_low = low_n;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (3 * DIV) @(negedge clk);
    check("frame_err_pulse", 32'(ferr_cnt_n - s_f), 32'd1);
    check("frame_err_no_perr", 32'(perr_cnt_n - s_p), 32'd0);
    check("frame_err_tx_idle", 32'(low_n - s_low), 32'd0);
    check("frame_err_lvl", 32'(lvl_n), 32'd0);

    // Glitch: four low cycles must not start a frame.
    s_f = ferr_cnt_n + perr_cnt_n + ovf_cnt_n; s_low = low_n;
    @(negedge clk);
    rx_n = 1'b0;
    repeat (4) @(negedge clk);
    rx_n = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    check("glitch_rx_idle", 32'(rx_st_n), 32'd0);
    check("glitch_no_flags", 32'(ferr_cnt_n + perr_cnt_n + ovf_cnt_n - s_f), 32'd0);
    check("glitch_lvl", 32'(lvl_n), 32'd0);
    check("glitch_tx_idle", 32'(low_n - s_low), 32'd0);

    // Overflow on the depth-4 instance with TX paused.
    pause_o = 1'b1;
    s_o = ovf_cnt_o; s_low = low_o;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_frame(2, 8'(b), 1'b0, 1'b0, 1'b1);
      if (b == 4) begin
        repeat (2) @(negedge clk);
        check("ovf_none_before_5th", 32'(ovf_cnt_o - s_o), 32'd0);
        check("ovf_lvl_4", 32'(lvl_o), 32'd4);
      end
    end
    repeat (4) @(negedge clk);
    check("ovf_one_pulse", 32'(ovf_cnt_o - s_o), 32'd1);
    check("ovf_lvl_still_4", 32'(lvl_o), 32'd4);
    check("ovf_tx_paused", 32'(low_o - s_low), 32'd0);
    pause_o = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_echo(2, 1'b0, falls[k]);
      if (k > 0) check("back_to_back_spacing", 32'(falls[k] - falls[k-1]), 32'(10 * DIV));
    end
    repeat (DIV) @(negedge clk);
    check("ovf_drained_lvl", 32'(lvl_o), 32'd0);

    // Reset in the middle of a TX data bit.
    pause_n = 1'b1;
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("paused_lvl_2", 32'(lvl_n), 32'd2);
    pause_n = 1'b0;
    w = 0;
    while (tx_n !== 1'b0 && w < TMO) begin
      @(negedge clk);
      w++;
    end
    check("pre_rst_tx_started", 32'(w < TMO), 32'd1);
    repeat (DIV + 2 * DIV + HALF) @(negedge clk);
    check("pre_rst_tx_data_low", 32'(tx_n), 32'd0);
    check("pre_rst_lvl_1", 32'(lvl_n), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_tx_high", 32'(tx_n), 32'd1);
    check("rst_async_lvl_0", 32'(lvl_n), 32'd0);
    check("rst_async_tx_idle", 32'(tx_st_n), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    exp_q.push_back(8'hF0);
    fork
      send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1);
      expect_echo(0, 1'b0, fall);
    join
    check("post_rst_push_to_start", 32'(fall - (rise_cyc_n - 1)), 32'd2);
    repeat (4) @(negedge clk);
    check("post_rst_lvl", 32'(lvl_n), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
